// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} after 34 cycles, or after 2 cycles for a zero divisor.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] a_abs, b_abs;
    logic [32:0] trial;
    logic [33:0] diff;
    logic [31:0] q_fix, r_fix;

    always_comb begin
        a_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        b_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        // Shift {rem, dvd} left by one; the MSB of dvd enters the remainder.
        trial = {rem[31:0], dvd[31]};
        diff  = {1'b0, trial} - {2'b00, dvs};
        q_fix = neg_q ? (~dvd + 32'd1) : dvd;
        r_fix = neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            rem      <= 33'd0;
            dvd      <= 32'd0;
            dvs      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BY_ZERO;
                        end else begin
                            state <= ON;
                            cnt   <= 6'd0;
                            rem   <= 33'd0;
                            dvd   <= a_abs;
                            dvs   <= b_abs;
                            neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_r <= signed_div_i && opdata1_i[31];
                        end
                    end
                end
                BY_ZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        state    <= END;
                        result_o <= 64'd0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                        cnt   <= 6'd0;
                    end else if (cnt != 6'd32) begin
                        // Borrow clear means the divisor fits: keep difference, quotient bit 1.
                        if (!diff[33]) begin
                            rem <= diff[32:0];
                            dvd <= {dvd[30:0], 1'b1};
                        end else begin
                            rem <= trial;
                            dvd <= {dvd[30:0], 1'b0};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        state    <= END;
                        cnt      <= 6'd0;
                        result_o <= {r_fix, q_fix};
                        ready_o  <= 1'b1;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// Randomized self-checking bench for ex_div against a plain-arithmetic division model.
module tb_ex_div;
    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;

    ex_div dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                           input int hold, output logic [63:0] got);
        int n;
        logic [63:0] exp;
        exp = ref_div(sg, a, b);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        // Operands must have been captured at the start edge.
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        n = 0;
        while (!ready_o && n < 60) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
        chk("result", result_o, exp);
        got = result_o;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_ready", {63'd0, ready_o}, 64'd1);
            chk("hold_result", result_o, exp);
        end
        start_i = 1'b0;
        tick();
        chk("drop_ready", {63'd0, ready_o}, 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        int rises;
        logic [31:0] a, b;
        bit sg;

        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        tick(); tick();
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_div(1'b0, 32'd100, 32'd7, 0, r);
        chk("divu_100_7", r, {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, 0, r);
        chk("div_m100_7", r, {32'hFFFFFFFE, 32'hFFFFFFF2});
        run_div(1'b1, 32'd100, 32'hFFFFFFF9, 0, r);
        chk("div_100_m7", r, {32'h00000002, 32'hFFFFFFF2});
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, r);
        chk("div_ovf", r, {32'h0, 32'h80000000});
        run_div(1'b0, 32'hDEADBEEF, 32'd0, 0, r);
        chk("div_zero", r, 64'd0);

        // Flush mid-division: no result may appear.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        repeat (10) tick();
        start_i = 1'b0; annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) rises++;
        end
        chk("annul_no_ready", 64'(rises), 64'd0);
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 0, r);
        chk("divu_after_annul", r, {32'hF, 32'h0FFFFFFF});

        // Reset mid-division.
        signed_div_i = 1'b1; opdata1_i = 32'h12345678; opdata2_i = 32'd9; start_i = 1'b1;
        tick();
        repeat (20) tick();
        rst = 1'b1; start_i = 1'b0;
        tick();
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        rst = 1'b0;
        tick();

        // start_i held through END: result held, no restart.
        run_div(1'b1, 32'hFFFF0000, 32'd12345, 8, r);

        // Flush while waiting in END.
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        tick();
        repeat (33) tick();
        chk("end_ready", {63'd0, ready_o}, 64'd1);
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0; start_i = 1'b0;
        chk("end_annul_ready", {63'd0, ready_o}, 64'd0);
        tick();

        for (int t = 0; t < 30; t++) begin
            sg = 1'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            run_div(sg, a, b, $urandom_range(0, 2), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
